// File: rtl/ms_slave_source.sv
// ms_slave_source: self-checking stimulus source for master/slave test blocks.
// Sends a burst of consecutive integers, one per sync strobe, and after a
// fixed latency compares the partner's reply against value + EXPECT_OFFSET.
// All outputs are registered. Reset is asynchronous and active-high.

module ms_slave_source #(
    parameter int unsigned        NUM_ITEMS     = 8,      // items per burst, 1..255
    parameter int unsigned        RESP_LATENCY  = 2,      // strobe-to-sample cycles, 1..15
    parameter logic signed [31:0] EXPECT_OFFSET = 32'sd0  // added to each item to form the expected reply
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [31:0] start_value,
    input  logic signed [31:0] m_in,
    output logic signed [31:0] s_out,
    output logic               s_out_sync,
    output logic               busy,
    output logic               done,
    output logic        [7:0]  mismatch_count,
    output logic signed [31:0] last_rx
);

    // Index of the final item; a CHECK at this index ends the burst.
    localparam logic [7:0] LAST_INDEX = 8'(NUM_ITEMS - 1);
    // WAIT runs while the counter counts down to zero, so loading
    // RESP_LATENCY-1 gives exactly RESP_LATENCY cycles in WAIT.
    localparam logic [3:0] WAIT_LOAD  = 4'(RESP_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEND   = 3'd1,
        S_WAIT   = 3'd2,
        S_CHECK  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // Registered state and datapath
    state_t      r_state;
    logic [31:0] r_base;
    logic [7:0]  r_index;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_s_out;
    logic        r_s_out_sync;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_mismatch;
    logic [31:0] r_last_rx;

    // Next-state values produced by the combinational block
    state_t      w_state_next;
    logic [31:0] w_base_next;
    logic [7:0]  w_index_next;
    logic [3:0]  w_wait_cnt_next;
    logic [31:0] w_s_out_next;
    logic        w_s_out_sync_next;
    logic        w_busy_next;
    logic        w_done_next;
    logic [7:0]  w_mismatch_next;
    logic [31:0] w_last_rx_next;

    // Current item and the reply expected for it; both wrap modulo 2^32.
    logic [31:0] w_item;
    logic [31:0] w_expected;
    logic        w_reply_bad;

    assign w_item      = r_base + 32'(r_index);
    assign w_expected  = w_item + EXPECT_OFFSET;
    assign w_reply_bad = (m_in != w_expected);

    // State register
    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-output decode for the burst sequencer
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // left one unassigned would infer a latch.
        w_state_next      = r_state;
        w_base_next       = r_base;
        w_index_next      = r_index;
        w_wait_cnt_next   = r_wait_cnt;
        w_s_out_next      = r_s_out;
        w_s_out_sync_next = 1'b0;
        w_busy_next       = r_busy;
        w_done_next       = 1'b0;
        w_mismatch_next   = r_mismatch;
        w_last_rx_next    = r_last_rx;

        case (r_state)
            S_IDLE: begin
                // start is only honoured here, so a busy source ignores it.
                if (start) begin
                    w_base_next     = start_value;
                    w_index_next    = 8'd0;
                    w_mismatch_next = 8'd0;
                    w_busy_next     = 1'b1;
                    w_state_next    = S_SEND;
                end
            end

            S_SEND: begin
                w_s_out_next      = w_item;
                w_s_out_sync_next = 1'b1;
                w_wait_cnt_next   = WAIT_LOAD;
                w_state_next      = S_WAIT;
            end

            S_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_next = S_CHECK;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 4'd1;
                end
            end

            S_CHECK: begin
                w_last_rx_next = m_in;
                // Saturate so a long run of bad replies never wraps to zero.
                if (w_reply_bad && (r_mismatch != 8'hFF)) begin
                    w_mismatch_next = r_mismatch + 8'd1;
                end
                if (r_index == LAST_INDEX) begin
                    w_state_next = S_FINISH;
                end else begin
                    w_index_next = r_index + 8'd1;
                    w_state_next = S_SEND;
                end
            end

            S_FINISH: begin
                // done and the falling busy become visible in the same cycle.
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base       <= '0;
            r_index      <= '0;
            r_wait_cnt   <= '0;
            r_s_out      <= '0;
            r_s_out_sync <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_mismatch   <= '0;
            r_last_rx    <= '0;
        end else begin
            r_base       <= w_base_next;
            r_index      <= w_index_next;
            r_wait_cnt   <= w_wait_cnt_next;
            r_s_out      <= w_s_out_next;
            r_s_out_sync <= w_s_out_sync_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_mismatch   <= w_mismatch_next;
            r_last_rx    <= w_last_rx_next;
        end
    end

    assign s_out          = r_s_out;
    assign s_out_sync     = r_s_out_sync;
    assign busy           = r_busy;
    assign done           = r_done;
    assign mismatch_count = r_mismatch;
    assign last_rx        = r_last_rx;

endmodule

// File: tb/tb_ms_slave_source.sv
// Testbench for ms_slave_source. Three instances with different parameter
// sets share one clock. Expected outputs come from a cycle-indexed model of
// the burst timeline (item k strobes after edge k*(L+2)+1, is checked on edge
// (k+1)*(L+2), done follows on edge N*(L+2)+1) and from the replies the
// bench itself presents on m_in at each check edge.

module tb_ms_slave_source;

    localparam int A_N = 8;
    localparam int A_L = 2;
    localparam int B_N = 4;
    localparam int B_L = 2;
    localparam int C_N = 3;
    localparam int C_L = 1;
    localparam logic [31:0] A_OFF = 32'd0;
    localparam logic [31:0] B_OFF = -32'sd5;
    localparam logic [31:0] C_OFF = 32'd0;

    localparam int M_LOOP     = 0;  // partner returns item + offset (matches)
    localparam int M_LOOP_BAD = 1;  // partner returns item + offset + 1
    localparam int M_ZERO     = 2;  // partner output held at 0
    localparam int M_RANDOM   = 3;  // per-cycle random mix of right and wrong

    logic        clk;
    logic        rst_u         [3];
    logic        start_u       [3];
    logic [31:0] start_value_u [3];
    logic [31:0] m_in_u        [3];
    logic [31:0] s_out_u       [3];
    logic        s_out_sync_u  [3];
    logic        busy_u        [3];
    logic        done_u        [3];
    logic [7:0]  mismatch_u    [3];
    logic [31:0] last_rx_u     [3];

    // Model state carried between bursts (outputs that hold across IDLE)
    logic [31:0] prev_s_out   [3];
    logic [31:0] prev_last_rx [3];

    int n_checks;
    int n_pass;

    ms_slave_source #(.NUM_ITEMS(A_N), .RESP_LATENCY(A_L), .EXPECT_OFFSET(A_OFF)) u_a (
        .clk(clk), .rst(rst_u[0]), .start(start_u[0]), .start_value(start_value_u[0]),
        .m_in(m_in_u[0]), .s_out(s_out_u[0]), .s_out_sync(s_out_sync_u[0]),
        .busy(busy_u[0]), .done(done_u[0]), .mismatch_count(mismatch_u[0]),
        .last_rx(last_rx_u[0])
    );

    ms_slave_source #(.NUM_ITEMS(B_N), .RESP_LATENCY(B_L), .EXPECT_OFFSET(B_OFF)) u_b (
        .clk(clk), .rst(rst_u[1]), .start(start_u[1]), .start_value(start_value_u[1]),
        .m_in(m_in_u[1]), .s_out(s_out_u[1]), .s_out_sync(s_out_sync_u[1]),
        .busy(busy_u[1]), .done(done_u[1]), .mismatch_count(mismatch_u[1]),
        .last_rx(last_rx_u[1])
    );

    ms_slave_source #(.NUM_ITEMS(C_N), .RESP_LATENCY(C_L), .EXPECT_OFFSET(C_OFF)) u_c (
        .clk(clk), .rst(rst_u[2]), .start(start_u[2]), .start_value(start_value_u[2]),
        .m_in(m_in_u[2]), .s_out(s_out_u[2]), .s_out_sync(s_out_sync_u[2]),
        .busy(busy_u[2]), .done(done_u[2]), .mismatch_count(mismatch_u[2]),
        .last_rx(last_rx_u[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All six outputs of instance u against the reset values
    task automatic check_all_zero(input int u, input string where);
        check($sformatf("u%0d %s s_out", u, where),      s_out_u[u], 32'd0);
        check($sformatf("u%0d %s sync", u, where),       {31'd0, s_out_sync_u[u]}, 32'd0);
        check($sformatf("u%0d %s busy", u, where),       {31'd0, busy_u[u]}, 32'd0);
        check($sformatf("u%0d %s done", u, where),       {31'd0, done_u[u]}, 32'd0);
        check($sformatf("u%0d %s mismatch", u, where),   {24'd0, mismatch_u[u]}, 32'd0);
        check($sformatf("u%0d %s last_rx", u, where),    last_rx_u[u], 32'd0);
    endtask

    // One burst on instance u, checked every cycle from the start edge until
    // two idle cycles after done. extra_start_c pulses start while busy;
    // abort_c asserts reset in the middle of that cycle and ends the burst.
    task automatic run_burst(input int u, input int n, input int lat, input logic [31:0] off,
                             input logic [31:0] base, input int mode,
                             input int extra_start_c, input int abort_c);
        logic [31:0] rx   [256];
        logic [31:0] hist [128];
        logic [31:0] exp_s_out;
        logic [31:0] exp_rx;
        int per, total, k_sent, k_done, mm;

        per   = lat + 2;
        total = n * per + 1;
        start_value_u[u] = base;
        start_u[u]       = 1'b1;
        @(posedge clk);
        #1;
        start_u[u] = 1'b0;

        for (int c = 0; c <= total + 2; c++) begin
            // Expected outputs after edge c (edge 0 is the start-sample edge)
            if (c == 0) begin
                exp_s_out = prev_s_out[u];
            end else begin
                k_sent = (c - 1) / per;
                if (k_sent > n - 1) k_sent = n - 1;
                exp_s_out = base + 32'(k_sent);
            end
            k_done = c / per;
            if (k_done > n) k_done = n;
            mm     = 0;
            exp_rx = prev_last_rx[u];
            for (int k = 0; k < k_done; k++) begin
                if (rx[k] !== base + 32'(k) + off) mm++;
                exp_rx = rx[k];
            end
            if (mm > 255) mm = 255;

            check($sformatf("u%0d c%0d s_out", u, c), s_out_u[u], exp_s_out);
            check($sformatf("u%0d c%0d sync", u, c), {31'd0, s_out_sync_u[u]},
                  {31'd0, (c >= 1 && (c - 1) % per == 0 && (c - 1) / per < n)});
            check($sformatf("u%0d c%0d busy", u, c), {31'd0, busy_u[u]}, {31'd0, (c <= n * per)});
            check($sformatf("u%0d c%0d done", u, c), {31'd0, done_u[u]}, {31'd0, (c == total)});
            check($sformatf("u%0d c%0d mismatch", u, c), {24'd0, mismatch_u[u]}, 32'(mm));
            check($sformatf("u%0d c%0d last_rx", u, c), last_rx_u[u], exp_rx);

            if (c == abort_c) begin
                #2;
                rst_u[u] = 1'b1;
                #1;
                check_all_zero(u, $sformatf("abort c%0d", c));
                @(negedge clk);
                rst_u[u] = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk);
                    #1;
                    check_all_zero(u, $sformatf("post-abort %0d", i));
                end
                prev_s_out[u]   = 32'd0;
                prev_last_rx[u] = 32'd0;
                return;
            end

            hist[c] = s_out_u[u];
            if (c == extra_start_c) begin
                start_u[u]       = 1'b1;
                start_value_u[u] = base + 32'd1000;
            end else begin
                start_u[u]       = 1'b0;
                start_value_u[u] = base;
            end

            // Partner reply presented for edge c+1
            if (c >= total) begin
                m_in_u[u] = $urandom;
            end else begin
                case (mode)
                    M_LOOP:     m_in_u[u] = ((c >= lat) ? hist[c - lat] : 32'd0) + off;
                    M_LOOP_BAD: m_in_u[u] = ((c >= lat) ? hist[c - lat] : 32'd0) + off + 32'd1;
                    M_ZERO:     m_in_u[u] = 32'd0;
                    default:    m_in_u[u] = ($urandom_range(0, 1) == 1) ? s_out_u[u] + off : $urandom;
                endcase
            end
            if ((c + 1) % per == 0 && (c + 1) / per <= n) begin
                rx[(c + 1) / per - 1] = m_in_u[u];
            end

            @(posedge clk);
            #1;
        end
        prev_s_out[u]   = base + 32'(n - 1);
        prev_last_rx[u] = rx[n - 1];
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int u = 0; u < 3; u++) begin
            rst_u[u]         = 1'b1;
            start_u[u]       = 1'b0;
            start_value_u[u] = 32'd0;
            m_in_u[u]        = 32'd0;
            prev_s_out[u]    = 32'd0;
            prev_last_rx[u]  = 32'd0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) check_all_zero(u, "reset");
        @(negedge clk);
        for (int u = 0; u < 3; u++) rst_u[u] = 1'b0;
        @(posedge clk);
        #1;

        // Loopback from 10: s_out 10..17, no mismatches, last_rx 17
        run_burst(0, A_N, A_L, A_OFF, 32'd10, M_LOOP, -1, -1);
        // Partner answers value+1: eight mismatches, last_rx 18
        run_burst(0, A_N, A_L, A_OFF, 32'd10, M_LOOP_BAD, -1, -1);
        // start pulsed during WAIT of item 3 is ignored
        run_burst(0, A_N, A_L, A_OFF, 32'd10, M_LOOP, 2 * (A_L + 2) + 2, -1);
        // Reset during WAIT of item 5, then a clean burst from index 0
        run_burst(0, A_N, A_L, A_OFF, 32'd40, M_LOOP_BAD, -1, 4 * (A_L + 2) + 2);
        run_burst(0, A_N, A_L, A_OFF, 32'd20, M_LOOP, -1, -1);

        // Signed wrap of items and of expected values
        run_burst(1, B_N, B_L, B_OFF, 32'h7FFF_FFFE, M_LOOP, -1, -1);
        run_burst(1, B_N, B_L, B_OFF, 32'h8000_0001, M_LOOP, -1, -1);
        run_burst(1, B_N, B_L, B_OFF, 32'hFFFF_FFFE, M_LOOP_BAD, -1, -1);

        // Latency 1, partner stuck at 0: only item 0 matches, done at edge 10
        run_burst(2, C_N, C_L, C_OFF, 32'd0, M_ZERO, -1, -1);

        // Randomised bursts on every instance
        for (int i = 0; i < 4; i++) begin
            run_burst(0, A_N, A_L, A_OFF, $urandom, M_RANDOM, -1, -1);
            run_burst(1, B_N, B_L, B_OFF, $urandom, M_RANDOM, -1, -1);
            run_burst(2, C_N, C_L, C_OFF, $urandom, M_RANDOM, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
